// File: rtl/sll_pkg.sv
// Shared ALU package: data-path sizing defaults and ALU op encodings.
// Imported by the shift-left-logical unit and its barrel shifter.
package sll_pkg;

  localparam int ALU_WIDTH   = 32;
  localparam int ALU_SHAMT_W = 5;

  typedef logic [ALU_SHAMT_W-1:0] shamt_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

endpackage

// File: rtl/sll_barrel.sv
// Combinational logarithmic left barrel shifter.
// Ports: a (data in), shamt (shift amount), y (a << shamt).
module sll_barrel
  import sll_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   y
);

  logic [WIDTH-1:0] stg [0:SHAMT_W];

  assign stg[0] = a;

  // Level k shifts by 2^k when shamt[k] is set.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_lvl
    assign stg[k+1] = shamt[k]
                    ? (stg[k] << (2 ** k))
                    : stg[k];
  end

  assign y = stg[SHAMT_W];

endmodule

// File: rtl/sll.sv
// Shift-left-logical unit: combinational result plus a
// one-deep valid/ready output register.
// Ports: clk, rst_n, a, b -> result (comb);
//   in_valid/in_ready capture, out_valid/out_ready/result_q.
module sll
  import sll_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_q
);

  logic capture;
  logic unused_b_hi;

  // Only the low shift-amount bits matter.
  assign unused_b_hi = ^b[WIDTH-1:SHAMT_W];

  sll_barrel #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_barrel (
    .a     (a),
    .shamt (b[SHAMT_W-1:0]),
    .y     (result)
  );

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result_q  <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      result_q  <= result;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sll.sv
// Directed self-checking bench for sll.
// Checks comb shifts, handshake, stall and async reset.
module tb_sll;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_q;

  int errors = 0;
  int checks = 0;

  sll dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .result    (result),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result_q  (result_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic comb(
    input string       tag,
    input logic [31:0] va,
    input logic [31:0] vb,
    input logic [31:0] exp
  );
    a = va;
    b = vb;
    #1;
    chk(tag, result, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result_q", result_q, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    comb("c_1_1", 32'h1, 32'd1, 32'h2);
    comb("c_3_4", 32'h3, 32'd4, 32'd48);
    comb("c_1_31", 32'h1, 32'd31, 32'h8000_0000);
    comb("c_ff_31", 32'hFFFF_FFFF, 32'd31,
         32'h8000_0000);
    comb("c_b0", 32'hDEAD_BEEF, 32'd0,
         32'hDEAD_BEEF);
    comb("c_b36", 32'h1234_5678, 32'd36,
         32'h2345_6780);
    comb("c_b32", 32'h5, 32'd32, 32'h5);
    comb("c_b33", 32'h5, 32'd33, 32'hA);
    comb("c_drop", 32'h8000_0001, 32'd1, 32'h2);
    comb("c_16", 32'h0000_ABCD, 32'd16,
         32'hABCD_0000);

    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a         = 32'd3;
    b         = 32'd4;
    step();
    chk("cap1_q", result_q, 32'd48);
    chk("cap1_v", {31'd0, out_valid}, 32'd1);

    a = 32'd1;
    b = 32'd5;
    step();
    chk("b2b1_q", result_q, 32'd32);
    chk("b2b1_v", {31'd0, out_valid}, 32'd1);

    a = 32'd7;
    b = 32'd8;
    step();
    chk("b2b2_q", result_q, 32'h700);
    chk("b2b2_v", {31'd0, out_valid}, 32'd1);

    out_ready = 1'b0;
    a         = 32'hF;
    b         = 32'd1;
    #1;
    chk("stall_rdy", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      a = a + 32'd1;
      chk("stall_q", result_q, 32'h700);
      chk("stall_v", {31'd0, out_valid}, 32'd1);
      chk("stall_r", {31'd0, in_ready}, 32'd0);
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("drain_v", {31'd0, out_valid}, 32'd0);
    chk("drain_q", result_q, 32'h700);
    chk("drain_r", {31'd0, in_ready}, 32'd1);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 32'd1;
    b         = 32'd2;
    step();
    in_valid = 1'b0;
    chk("cap2_q", result_q, 32'd4);
    chk("cap2_v", {31'd0, out_valid}, 32'd1);

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_v", {31'd0, out_valid}, 32'd0);
    chk("arst_q", result_q, 32'd0);
    chk("arst_comb", result, 32'd4);

    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    a        = 32'd9;
    b        = 32'd1;
    step();
    chk("post_q", result_q, 32'd18);
    chk("post_v", {31'd0, out_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
